// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, 33-cycle busy window.
// Optional macro MULDIV_DIV0_TRAP_EN: divide by zero is trapped at accept (div0+done pulse, no run).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             Unsigned,
  input  logic             WriteHi,
  input  logic             WriteLo,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 is_div_r;
  logic                 neg_q_r;
  logic                 neg_r_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 start_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [WIDTH-1:0]     rem_next_s;
  logic [WIDTH-1:0]     q_next_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     hi_fix_s;
  logic [WIDTH-1:0]     lo_fix_s;

  // Magnitude of an operand; raw value when the operation is unsigned
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
  endfunction

  assign start_s = start_mul | start_div;
  assign prod_s  = {rem_r, q_r};

  // One iteration of the datapath plus the final sign fixup
  always_comb begin
    mul_sum_s   = {1'b0, rem_r} + (q_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_r, q_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, a_r};
    rem_next_s  = rem_r;
    q_next_s    = q_r;
    prod_fix_s  = prod_s;
    hi_fix_s    = rem_r;
    lo_fix_s    = q_r;
    if (is_div_r) begin
      // A zero divisor always "fits", which yields an all-ones quotient and the dividend as remainder
      if (div_shift_s >= {1'b0, a_r}) begin
        rem_next_s = div_diff_s[WIDTH-1:0];
        q_next_s   = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_next_s = div_shift_s[WIDTH-1:0];
        q_next_s   = {q_r[WIDTH-2:0], 1'b0};
      end
      lo_fix_s = neg_q_r ? -q_r : q_r;
      hi_fix_s = neg_r_r ? -rem_r : rem_r;
    end else begin
      rem_next_s = mul_sum_s[WIDTH:1];
      q_next_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
      prod_fix_s = neg_q_r ? -prod_s : prod_s;
      hi_fix_s   = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s   = prod_fix_s[WIDTH-1:0];
    end
  end

`ifdef MULDIV_DIV0_TRAP_EN
  logic div0_r;
  logic trap_s;

  assign trap_s = start_div & ~start_mul & (op2 == {WIDTH{1'b0}});
  assign div0   = div0_r;

  // Divide-by-zero pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div0_r <= 1'b0;
    end else begin
      div0_r <= (state_r == ST_IDLE) && trap_s;
    end
  end
`else
  logic trap_s;

  assign trap_s = 1'b0;
  assign div0   = 1'b0;
`endif

  // Control FSM, operand latches, iteration registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s && trap_s) begin
            done_r <= 1'b1;
          end else if (start_s) begin
            is_div_r <= ~start_mul;
            a_r      <= start_mul ? mag(op1, ~Unsigned) : mag(op2, ~Unsigned);
            q_r      <= start_mul ? mag(op2, ~Unsigned) : mag(op1, ~Unsigned);
            rem_r    <= {WIDTH{1'b0}};
            neg_q_r  <= ~Unsigned & (op1[WIDTH-1] ^ op2[WIDTH-1]);
            neg_r_r  <= ~Unsigned & op1[WIDTH-1];
            cnt_r    <= CW'(WIDTH - 1);
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            if (WriteHi) begin
              hi_r <= op1;
            end else begin
              hi_r <= hi_r;
            end
            if (WriteLo) begin
              lo_r <= op1;
            end else begin
              lo_r <= lo_r;
            end
          end
        end
        ST_RUN: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIX: begin
          hi_r    <= hi_fix_s;
          lo_r    <= lo_fix_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit: arithmetic vectors, latency, hazards, reset abort, div-by-zero.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start_mul;
  logic        start_div;
  logic        Unsigned;
  logic        WriteHi;
  logic        WriteLo;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        smul;
    logic        sdiv;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op1       (op1),
    .op2       (op2),
    .start_mul (start_mul),
    .start_div (start_div),
    .Unsigned  (Unsigned),
    .WriteHi   (WriteHi),
    .WriteLo   (WriteLo),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start_mul = 1'b0;
    start_div = 1'b0;
    WriteHi   = 1'b0;
    WriteLo   = 1'b0;
  endtask

  // Launch one operation, watch the busy window, then compare the result
  task automatic run_op(input string nm, input logic smul, input logic sdiv, input logic uns,
                        input logic [31:0] a, input logic [31:0] b, input logic wh, input logic wl,
                        input bit inj, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          bc;
    bit          hold_ok;
    bit          got_done;
    @(negedge clk);
    old_hi = hi;
    old_lo = lo;
    op1 = a; op2 = b; Unsigned = uns;
    start_mul = smul; start_div = sdiv; WriteHi = wh; WriteLo = wl;
    @(posedge clk);
    #1;
    clear_inputs();
    op1 = 32'hDEAD_BEEF; op2 = 32'h0BAD_F00D; Unsigned = ~uns;
    bc = 0; hold_ok = 1'b1; got_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) bc++;
      if (hi !== old_hi || lo !== old_lo || div0 !== 1'b0) hold_ok = 1'b0;
      if (inj && bc == 10) begin
        WriteHi = 1'b1; WriteLo = 1'b1; start_div = 1'b1; start_mul = 1'b1;
        op1 = 32'h5555_AAAA; op2 = 32'h0000_0000;
      end else begin
        clear_inputs();
      end
    end
    clear_inputs();
    chk({nm, ".done_seen"}, {63'd0, got_done}, 64'd1);
    chk({nm, ".busy_cycles"}, 64'(bc), 64'd33);
    chk({nm, ".hold"}, {63'd0, hold_ok}, 64'd1);
    chk({nm, ".result"}, {hi, lo}, {ehi, elo});
    @(negedge clk);
    chk({nm, ".done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    bit bad;
    rst_n = 1'b0;
    op1 = 32'd0; op2 = 32'd0; Unsigned = 1'b0;
    clear_inputs();

    vecs.push_back('{"mul_signed",   1'b1, 1'b0, 1'b0, 32'd28562,    32'hFFFF_FEDC, 32'hFFFF_FFFF, 32'hFF80_BD78});
    vecs.push_back('{"div_neg_dvd",  1'b0, 1'b1, 1'b0, 32'hFFFF_F66C, 32'd24,       32'hFFFF_FFFC, 32'hFFFF_FF9A});
    vecs.push_back('{"div_neg_dvs",  1'b0, 1'b1, 1'b0, 32'd2452,     32'hFFFF_FFE8, 32'd4,         32'hFFFF_FF9A});
    vecs.push_back('{"divu_small",   1'b0, 1'b1, 1'b1, 32'd572,      32'd5294,      32'd572,       32'd0});
    vecs.push_back('{"multu_max",    1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"div_ovf",      1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{"mult_minmin",  1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    vecs.push_back('{"mult_m1m1",    1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1});
    vecs.push_back('{"mult_7xm3",    1'b1, 1'b0, 1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"multu_shift",  1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0010, 32'd1,         32'h2345_6780});
    vecs.push_back('{"div_m7by2",    1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_big",     1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF});
    vecs.push_back('{"div_m1by2",    1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{"both_mulwins", 1'b1, 1'b1, 1'b0, 32'd6,        32'd3,         32'd0,         32'd18});

    repeat (3) @(negedge clk);
    chk("reset_in", {30'd0, busy, done, div0, hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out", {30'd0, busy, done, div0, hi, lo}, 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].smul, vecs[i].sdiv, vecs[i].uns, vecs[i].a, vecs[i].b,
             1'b0, 1'b0, 1'b0, vecs[i].ehi, vecs[i].elo);

    // MTHI / MTLO while idle, then both together
    @(negedge clk);
    op1 = 32'd3576; WriteHi = 1'b1;
    @(negedge clk);
    WriteHi = 1'b0;
    chk("mthi", {hi, lo}, {32'd3576, 32'd18});
    op1 = 32'd258; WriteLo = 1'b1;
    @(negedge clk);
    WriteLo = 1'b0;
    chk("mtlo", {hi, lo}, {32'd3576, 32'd258});
    op1 = 32'hCAFE_0001; WriteHi = 1'b1; WriteLo = 1'b1;
    @(negedge clk);
    clear_inputs();
    chk("mt_both", {hi, lo}, {32'hCAFE_0001, 32'hCAFE_0001});

    // Start alongside a write: write dropped (hold check would see hi/lo change)
    run_op("start_vs_write", 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'd0, 32'd35);
    // Pulses during busy are ignored
    run_op("busy_inject", 1'b0, 1'b1, 1'b1, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b1, 32'd6, 32'd142);

`ifdef MULDIV_DIV0_TRAP_EN
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd0; Unsigned = 1'b1; start_div = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("div0_pulse", {61'd0, div0, done, busy}, {61'd0, 3'b110});
    chk("div0_hold", {hi, lo}, {32'd6, 32'd142});
    @(negedge clk);
    chk("div0_end", {61'd0, div0, done, busy}, 64'd0);
`else
    run_op("divu_by0", 1'b0, 1'b1, 1'b1, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_by0_neg", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd1);
`endif

    // Reset in the middle of a multiply
    @(negedge clk);
    op1 = 32'd3; op2 = 32'd5; Unsigned = 1'b1; start_mul = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (15) @(negedge clk);
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort", {30'd0, busy, done, div0, hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy || hi != 32'd0 || lo != 32'd0) bad = 1'b1;
    end
    chk("abort_quiet", {63'd0, bad}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
